// File: rtl/rv32i_ctrl_pipe.sv
// rv32i_ctrl_pipe: per-stage control word / rd / PC carrier for the RV32I back end,
// with stall back-propagation, bubble insertion, flush and a hazard scoreboard.

package rv32i_pkg;
    localparam int unsigned REG_W = 5;
    localparam int unsigned XLEN  = 32;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef struct packed {
        rv32i_opcode opcode;
        logic [2:0]  aluop;
        logic [2:0]  cmpop;
        logic        load_regfile;
        logic        mem_read;
        logic        mem_write;
        logic [3:0]  mem_byte_enable;
        logic [2:0]  regfilemux_sel;
        logic        alumux1_sel;
        logic [2:0]  alumux2_sel;
    } rv32i_control_word;
endpackage

module rv32i_ctrl_pipe
    import rv32i_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned IDX_W      = $clog2(NUM_STAGES)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    input  rv32i_control_word                   in_cw,
    input  logic [REG_W-1:0]                    in_rd,
    input  logic [XLEN-1:0]                     in_pc,
    output logic                                in_ready,
    input  logic [NUM_STAGES-1:0]               stall,
    input  logic [NUM_STAGES-1:0]               flush,
    output logic [NUM_STAGES-1:0]               stg_valid,
    output rv32i_control_word [NUM_STAGES-1:0]  stg_cw,
    output logic [NUM_STAGES-1:0][REG_W-1:0]    stg_rd,
    output logic [NUM_STAGES-1:0][XLEN-1:0]     stg_pc,
    input  logic [REG_W-1:0]                    q_rs1,
    input  logic [REG_W-1:0]                    q_rs2,
    output logic                                hit1,
    output logic                                hit2,
    output logic [IDX_W-1:0]                    fwd_stg1,
    output logic [IDX_W-1:0]                    fwd_stg2,
    output logic                                load_use
);

    logic [NUM_STAGES-1:0]             valid_q, valid_d;
    rv32i_control_word [NUM_STAGES-1:0] cw_q, cw_d;
    logic [NUM_STAGES-1:0][REG_W-1:0]  rd_q, rd_d;
    logic [NUM_STAGES-1:0][XLEN-1:0]   pc_q, pc_d;
    logic [NUM_STAGES-1:0]             hold;
    logic [NUM_STAGES-1:0]             match1, match2;

    // Effective hold: a stall in any older stage also freezes this one.
    always_comb begin
        hold = '0;
        hold[NUM_STAGES-1] = stall[NUM_STAGES-1];
        for (int k = int'(NUM_STAGES) - 2; k >= 0; k--) begin
            hold[k] = hold[k+1] | stall[k];
        end
    end

    assign in_ready = ~hold[0];

    // Next-state per stage: flush-under-hold, hold, bubble, then advance.
    always_comb begin
        valid_d = valid_q;
        cw_d    = cw_q;
        rd_d    = rd_q;
        pc_d    = pc_q;

        if (flush[0] && hold[0]) begin
            valid_d[0] = 1'b0;
        end else if (!hold[0]) begin
            valid_d[0] = in_valid;
            cw_d[0]    = in_cw;
            rd_d[0]    = in_rd;
            pc_d[0]    = in_pc;
        end

        for (int k = 1; k < int'(NUM_STAGES); k++) begin
            if (flush[k] && hold[k]) begin
                valid_d[k] = 1'b0;
            end else if (!hold[k]) begin
                if (stall[k-1]) begin
                    valid_d[k] = 1'b0;
                end else begin
                    valid_d[k] = valid_q[k-1] & ~flush[k-1];
                    cw_d[k]    = cw_q[k-1];
                    rd_d[k]    = rd_q[k-1];
                    pc_d[k]    = pc_q[k-1];
                end
            end
        end
    end

    // Stage registers with synchronous reset overriding stall and flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            cw_q    <= '0;
            rd_q    <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            cw_q    <= cw_d;
            rd_q    <= rd_d;
            pc_q    <= pc_d;
        end
    end

    assign stg_valid = valid_q;
    assign stg_cw    = cw_q;
    assign stg_rd    = rd_q;
    assign stg_pc    = pc_q;

    // Hazard scoreboard from registered state; youngest matching stage wins.
    always_comb begin
        match1   = '0;
        match2   = '0;
        fwd_stg1 = '0;
        fwd_stg2 = '0;
        for (int k = 0; k < int'(NUM_STAGES); k++) begin
            match1[k] = valid_q[k] & cw_q[k].load_regfile & (rd_q[k] == q_rs1) & (q_rs1 != '0);
            match2[k] = valid_q[k] & cw_q[k].load_regfile & (rd_q[k] == q_rs2) & (q_rs2 != '0);
        end
        for (int k = int'(NUM_STAGES) - 1; k >= 0; k--) begin
            if (match1[k]) fwd_stg1 = IDX_W'(k);
            if (match2[k]) fwd_stg2 = IDX_W'(k);
        end
        hit1     = |match1;
        hit2     = |match2;
        load_use = (match1[0] | match2[0]) & (cw_q[0].opcode == op_load) & valid_q[0];
    end

endmodule

// File: tb/tb_rv32i_ctrl_pipe.sv
// Bench for rv32i_ctrl_pipe: three instances (2, 4, 8 stages) share one stimulus
// stream; an in-flight instruction list predicts occupancy, hazards and retirement.

module tb_rv32i_ctrl_pipe;
    import rv32i_pkg::*;

    localparam int unsigned CW_W = $bits(rv32i_control_word);

    typedef struct packed {
        logic [1:0]                c;
        logic                      in_ready;
        logic [7:0]                valid;
        logic [7:0][31:0]          pc;
        logic [7:0][4:0]           rd;
        rv32i_control_word [7:0]   cw;
        logic                      hit1;
        logic [2:0]                fwd1;
        logic                      hit2;
        logic [2:0]                fwd2;
        logic                      load_use;
    } exp_t;

    typedef struct {
        int                c;
        int                stage;
        logic [31:0]       pc;
        logic [4:0]        rd;
        rv32i_control_word cw;
    } rec_t;

    logic clk = 1'b0;
    logic rst, in_valid;
    rv32i_control_word in_cw;
    logic [4:0]  in_rd, q_rs1, q_rs2;
    logic [31:0] in_pc;
    logic [7:0]  stall, flush;
    logic [2:0]  rdy, h1, h2, lu;

    logic [1:0] v2; rv32i_control_word [1:0] cw2; logic [1:0][4:0] rd2; logic [1:0][31:0] pc2;
    logic [0:0] f1_2, f2_2;
    logic [3:0] v4; rv32i_control_word [3:0] cw4; logic [3:0][4:0] rd4; logic [3:0][31:0] pc4;
    logic [1:0] f1_4, f2_4;
    logic [7:0] v8; rv32i_control_word [7:0] cw8; logic [7:0][4:0] rd8; logic [7:0][31:0] pc8;
    logic [2:0] f1_8, f2_8;

    always #5 clk = ~clk;

    rv32i_ctrl_pipe #(.NUM_STAGES(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_cw(in_cw), .in_rd(in_rd), .in_pc(in_pc),
        .in_ready(rdy[0]), .stall(stall[1:0]), .flush(flush[1:0]), .stg_valid(v2), .stg_cw(cw2),
        .stg_rd(rd2), .stg_pc(pc2), .q_rs1(q_rs1), .q_rs2(q_rs2), .hit1(h1[0]), .hit2(h2[0]),
        .fwd_stg1(f1_2), .fwd_stg2(f2_2), .load_use(lu[0]));

    rv32i_ctrl_pipe #(.NUM_STAGES(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_cw(in_cw), .in_rd(in_rd), .in_pc(in_pc),
        .in_ready(rdy[1]), .stall(stall[3:0]), .flush(flush[3:0]), .stg_valid(v4), .stg_cw(cw4),
        .stg_rd(rd4), .stg_pc(pc4), .q_rs1(q_rs1), .q_rs2(q_rs2), .hit1(h1[1]), .hit2(h2[1]),
        .fwd_stg1(f1_4), .fwd_stg2(f2_4), .load_use(lu[1]));

    rv32i_ctrl_pipe #(.NUM_STAGES(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_cw(in_cw), .in_rd(in_rd), .in_pc(in_pc),
        .in_ready(rdy[2]), .stall(stall), .flush(flush), .stg_valid(v8), .stg_cw(cw8),
        .stg_rd(rd8), .stg_pc(pc8), .q_rs1(q_rs1), .q_rs2(q_rs2), .hit1(h1[2]), .hit2(h2[2]),
        .fwd_stg1(f1_8), .fwd_stg2(f2_8), .load_use(lu[2]));

    int n_run = 0;
    int n_fail = 0;
    exp_t exp_q[$];
    rec_t inflight[$];
    logic [31:0] ret0[$], ret1[$], ret2[$];
    logic fin_req = 1'b0;
    logic mon_done = 1'b0;

    logic [31:0] nx_pc;
    rv32i_control_word nx_cw;
    logic [4:0] nx_rd, nx_rs1, nx_rs2;

    function automatic int cfg_n(int c);
        return (c == 0) ? 2 : (c == 1) ? 4 : 8;
    endfunction

    // Stage s of an n-stage pipe is frozen when any stage at or beyond s stalls.
    function automatic bit held(logic [7:0] st, int n, int s);
        logic [7:0] m;
        m = 8'((1 << n) - 1);
        return ((st & m) >> s) != 8'd0;
    endfunction

    task automatic ret_push(int c, logic [31:0] pc);
        if (c == 0) ret0.push_back(pc);
        else if (c == 1) ret1.push_back(pc);
        else ret2.push_back(pc);
    endtask

    function automatic int ret_size(int c);
        return (c == 0) ? ret0.size() : (c == 1) ? ret1.size() : ret2.size();
    endfunction

    task automatic ret_pop(int c, output logic [31:0] pc);
        if (c == 0) pc = ret0.pop_front();
        else if (c == 1) pc = ret1.pop_front();
        else pc = ret2.pop_front();
    endtask

    // Expected combinational/registered view of config c from the in-flight list.
    function automatic exp_t model_expect(int c, logic [4:0] rs1, logic [4:0] rs2, logic [7:0] st);
        exp_t e;
        int b1, b2;
        logic s0_load;
        e = '0;
        e.c = 2'(c);
        e.in_ready = !held(st, cfg_n(c), 0);
        b1 = 8; b2 = 8; s0_load = 1'b0;
        foreach (inflight[i]) begin
            if (inflight[i].c == c) begin
                e.valid[inflight[i].stage] = 1'b1;
                e.pc[inflight[i].stage] = inflight[i].pc;
                e.rd[inflight[i].stage] = inflight[i].rd;
                e.cw[inflight[i].stage] = inflight[i].cw;
                if (inflight[i].stage == 0 && inflight[i].cw.opcode == op_load) s0_load = 1'b1;
                if (inflight[i].cw.load_regfile && rs1 != 5'd0 && inflight[i].rd == rs1 && inflight[i].stage < b1)
                    b1 = inflight[i].stage;
                if (inflight[i].cw.load_regfile && rs2 != 5'd0 && inflight[i].rd == rs2 && inflight[i].stage < b2)
                    b2 = inflight[i].stage;
            end
        end
        e.hit1 = (b1 < 8);
        e.hit2 = (b2 < 8);
        e.fwd1 = e.hit1 ? 3'(b1) : 3'd0;
        e.fwd2 = e.hit2 ? 3'(b2) : 3'd0;
        e.load_use = ((b1 == 0) || (b2 == 0)) && s0_load;
        return e;
    endfunction

    // Advance every in-flight instruction across one clock edge.
    task automatic model_step(logic r, logic v, logic [7:0] st, logic [7:0] fs);
        rec_t nl[$];
        rec_t rec;
        if (r) begin
            inflight.delete();
            return;
        end
        foreach (inflight[i]) begin
            rec = inflight[i];
            if (fs[rec.stage]) continue;
            if (held(st, cfg_n(rec.c), rec.stage)) nl.push_back(rec);
            else if (rec.stage == cfg_n(rec.c) - 1) ret_push(rec.c, rec.pc);
            else begin
                rec.stage++;
                nl.push_back(rec);
            end
        end
        for (int c = 0; c < 3; c++) begin
            if (v && !held(st, cfg_n(c), 0)) begin
                rec.c = c; rec.stage = 0; rec.pc = nx_pc; rec.rd = nx_rd; rec.cw = nx_cw;
                nl.push_back(rec);
            end
        end
        inflight = nl;
    endtask

    task automatic drive(logic r, logic v, logic [7:0] st, logic [7:0] fs);
        @(negedge clk);
        rst = r; in_valid = v; stall = st; flush = fs;
        in_pc = nx_pc; in_cw = nx_cw; in_rd = nx_rd; q_rs1 = nx_rs1; q_rs2 = nx_rs2;
        for (int c = 0; c < 3; c++) exp_q.push_back(model_expect(c, nx_rs1, nx_rs2, st));
        model_step(r, v, st, fs);
        if (v) nx_pc = nx_pc + 32'd4;
    endtask

    task automatic rand_payload();
        nx_rd = 5'($urandom_range(0, 7));
        nx_cw = rv32i_control_word'(CW_W'($urandom));
        case ($urandom_range(0, 3))
            0: nx_cw.opcode = op_load;
            1: nx_cw.opcode = op_reg;
            2: nx_cw.opcode = op_store;
            default: nx_cw.opcode = op_br;
        endcase
        nx_cw.load_regfile = ($urandom_range(0, 3) != 0);
    endtask

    task automatic set_instr(rv32i_opcode op, logic lr, logic [4:0] rd);
        nx_cw = '0;
        nx_cw.opcode = op;
        nx_cw.load_regfile = lr;
        nx_rd = rd;
    endtask

    function automatic exp_t observe(int c);
        exp_t o;
        o = '0;
        o.c = 2'(c);
        o.in_ready = rdy[c];
        o.hit1 = h1[c];
        o.hit2 = h2[c];
        o.load_use = lu[c];
        case (c)
            0: begin
                o.valid = 8'(v2);
                for (int k = 0; k < 2; k++) begin o.pc[k] = pc2[k]; o.rd[k] = rd2[k]; o.cw[k] = cw2[k]; end
                o.fwd1 = 3'(f1_2); o.fwd2 = 3'(f2_2);
            end
            1: begin
                o.valid = 8'(v4);
                for (int k = 0; k < 4; k++) begin o.pc[k] = pc4[k]; o.rd[k] = rd4[k]; o.cw[k] = cw4[k]; end
                o.fwd1 = 3'(f1_4); o.fwd2 = 3'(f2_4);
            end
            default: begin
                o.valid = v8;
                for (int k = 0; k < 8; k++) begin o.pc[k] = pc8[k]; o.rd[k] = rd8[k]; o.cw[k] = cw8[k]; end
                o.fwd1 = f1_8; o.fwd2 = f2_8;
            end
        endcase
        return o;
    endfunction

    task automatic check(string name, int c, logic [63:0] act, logic [63:0] req);
        n_run++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s N=%0d t=%0t: got 0x%0h expected 0x%0h", name, cfg_n(c), $time, act, req);
        end
    endtask

    // Monitor: pop per-cycle expectations and retirements, compare with the DUTs.
    always @(negedge clk) begin
        exp_t e, o;
        int c, n;
        logic [31:0] rpc;
        #2;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            c = int'(e.c);
            n = cfg_n(c);
            o = observe(c);
            check("in_ready", c, 64'(o.in_ready), 64'(e.in_ready));
            check("stg_valid", c, 64'(o.valid), 64'(e.valid));
            for (int k = 0; k < n; k++) begin
                if (e.valid[k])
                    check($sformatf("stage%0d_payload", k), c, {o.pc[k], o.rd[k], o.cw[k]}, {e.pc[k], e.rd[k], e.cw[k]});
            end
            check("hit1", c, 64'(o.hit1), 64'(e.hit1));
            check("fwd_stg1", c, 64'(o.fwd1), 64'(e.fwd1));
            check("hit2", c, 64'(o.hit2), 64'(e.hit2));
            check("fwd_stg2", c, 64'(o.fwd2), 64'(e.fwd2));
            check("load_use", c, 64'(o.load_use), 64'(e.load_use));
            if (o.valid[n-1] && !flush[n-1] && !stall[n-1] && !rst) begin
                if (ret_size(c) == 0) begin
                    n_run++;
                    n_fail++;
                    $display("FAIL retire_unexpected N=%0d t=%0t: got pc 0x%0h expected no retirement", n, $time, o.pc[n-1]);
                end else begin
                    ret_pop(c, rpc);
                    check("retire_pc", c, 64'(o.pc[n-1]), 64'(rpc));
                end
            end
        end
        if (fin_req && !mon_done) begin
            for (int k = 0; k < 3; k++) check("retire_missing", k, 64'(ret_size(k)), 64'd0);
            mon_done = 1'b1;
        end
    end

    initial begin
        logic [7:0] st, fs;
        logic r;
        rst = 1'b1; in_valid = 1'b0; stall = '0; flush = '0;
        in_pc = '0; in_cw = '0; in_rd = '0; q_rs1 = '0; q_rs2 = '0;
        nx_pc = 32'h100; nx_rs1 = '0; nx_rs2 = '0;
        rand_payload();

        // Reset, then six back-to-back instructions from 0x100.
        drive(1'b1, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 8'h00, 8'h00);
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 6; i++) begin rand_payload(); drive(1'b0, 1'b1, 8'h00, 8'h00); end
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 8'h00, 8'h00);

        // stall[2] held two cycles mid-stream.
        for (int i = 0; i < 8; i++) begin
            rand_payload();
            drive(1'b0, 1'b1, (i == 3 || i == 4) ? 8'h04 : 8'h00, 8'h00);
        end
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 8'h00, 8'h00);

        // flush[1] with stall[1], then flush[0]|flush[1] unheld.
        for (int i = 0; i < 4; i++) begin rand_payload(); drive(1'b0, 1'b1, 8'h00, 8'h00); end
        rand_payload(); drive(1'b0, 1'b1, 8'h02, 8'h02);
        rand_payload(); drive(1'b0, 1'b1, 8'h00, 8'h03);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 8'h00, 8'h00);

        // Load-use: add x5, non-writer, lw x5; then probe with the pipe frozen.
        set_instr(op_reg, 1'b1, 5'd5);  drive(1'b0, 1'b1, 8'h00, 8'h00);
        set_instr(op_reg, 1'b0, 5'd1);  drive(1'b0, 1'b1, 8'h00, 8'h00);
        set_instr(op_load, 1'b1, 5'd5); drive(1'b0, 1'b1, 8'h00, 8'h00);
        nx_rs1 = 5'd5; drive(1'b0, 1'b0, 8'hFF, 8'h00);
        nx_rs1 = 5'd0; drive(1'b0, 1'b0, 8'hFF, 8'h00);
        drive(1'b0, 1'b0, 8'hFF, 8'h01);
        nx_rs1 = 5'd5; nx_rs2 = 5'd5; drive(1'b0, 1'b0, 8'hFF, 8'h00);
        nx_rs1 = 5'd0; nx_rs2 = 5'd0;
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 8'h00, 8'h00);

        // Reset while the full pipe is frozen.
        for (int i = 0; i < 8; i++) begin rand_payload(); drive(1'b0, 1'b1, 8'h00, 8'h00); end
        drive(1'b0, 1'b0, 8'hFF, 8'h00);
        drive(1'b1, 1'b1, 8'hFF, 8'h0F);
        drive(1'b0, 1'b0, 8'hFF, 8'h00);
        drive(1'b0, 1'b0, 8'h00, 8'h00);

        // Random regression.
        for (int i = 0; i < 3000; i++) begin
            rand_payload();
            nx_rs1 = 5'($urandom_range(0, 7));
            nx_rs2 = 5'($urandom_range(0, 7));
            st = '0; fs = '0;
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 15) == 0) st[b] = 1'b1;
                if ($urandom_range(0, 15) == 0) fs[b] = 1'b1;
            end
            r = ($urandom_range(0, 199) == 0);
            drive(r, ($urandom_range(0, 3) != 0), st, fs);
        end
        nx_rs1 = '0; nx_rs2 = '0;
        for (int i = 0; i < 12; i++) drive(1'b0, 1'b0, 8'h00, 8'h00);

        fin_req = 1'b1;
        for (int i = 0; i < 10 && !mon_done; i++) @(negedge clk);
        if (!mon_done) begin
            $display("FAIL monitor_timeout: got no end-of-run check, expected one within 10 cycles");
            $fatal(1, "monitor did not complete");
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
